// File: rtl/waveform_capture_buffer.sv
// ---------------------------------------------------------------------------
// waveform_capture_buffer
//
// Captures {signal, modulation} sample pairs into an on-chip frame buffer,
// starting at a rising level crossing on the signal channel. The display side
// reads the frozen frame back by address at any time.
//
// Optional feature: define CAPTURE_TIMEOUT_EN to auto-trigger a frame after
// TIMEOUT sample strobes spent in ARMED without a genuine crossing.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   sample_en   sample strobe, one capture opportunity per high cycle
//   signal_in   selected signal sample (unsigned, offset binary)
//   mod_in      selected modulation sample (unsigned, offset binary)
//   arm         single-cycle pulse, starts a new trigger/capture sequence
//   trig_level  trigger threshold (unsigned)
//   rd_addr     buffer read address
//   rd_data     {signal, modulation} at rd_addr, one cycle read latency
//   busy        high while ARMED or CAPTURE
//   done        high while DONE
//   timed_out   current frame was auto-triggered (0 unless CAPTURE_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module waveform_capture_buffer #(
  parameter int W       = 12,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_en,
  input  logic [W-1:0]      signal_in,
  input  logic [W-1:0]      mod_in,
  input  logic              arm,
  input  logic [W-1:0]      trig_level,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [2*W-1:0]    rd_data,
  output logic              busy,
  output logic              done,
  output logic              timed_out
);

  if (((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_param_check
    $error("waveform_capture_buffer: DEPTH must be a power of two and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Rising crossing: previous sample strictly below the level, current at or
  // above it. A level of zero can never be crossed.
  function automatic logic crossing(input logic [W-1:0] prev,
                                    input logic [W-1:0] cur,
                                    input logic [W-1:0] lvl);
    return (prev < lvl) && (cur >= lvl);
  endfunction

  state_t              state;
  state_t              state_nxt;
  logic                busy_nxt;
  logic                done_nxt;

  logic [W-1:0]        prev_sample;
  logic                prev_vld;
  logic [ADDR_W-1:0]   wr_ptr;

  logic                arm_acc;
  logic                armed_strobe;
  logic                trig_hit;
  logic                force_hit;
  logic                start_cap;

  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [2*W-1:0]      wdata;

  logic [2*W-1:0]      mem [DEPTH];

  // arm is only honoured when no sequence is in flight.
  assign arm_acc      = arm && ((state == S_IDLE) || (state == S_DONE));
  assign armed_strobe = (state == S_ARMED) && sample_en;
  assign trig_hit     = prev_vld && crossing(prev_sample, signal_in, trig_level);
  assign start_cap    = armed_strobe && (trig_hit || force_hit);

`ifdef CAPTURE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             timed_out_q;

  // Once TIMEOUT strobes have been seen in ARMED, the next one is forced.
  assign force_hit = (to_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt      <= '0;
      timed_out_q <= 1'b0;
    end else if (arm_acc) begin
      to_cnt      <= '0;
      timed_out_q <= 1'b0;
    end else if (armed_strobe) begin
      if (!force_hit) begin
        to_cnt <= to_cnt + CNT_W'(1);
      end
      // A genuine crossing on the timeout strobe is not reported as a timeout.
      if (force_hit && !trig_hit) begin
        timed_out_q <= 1'b1;
      end
    end
  end

  assign timed_out = timed_out_q;
`else
  assign force_hit = 1'b0;
  assign timed_out = 1'b0;
`endif

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- FSM: next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (arm) state_nxt = S_ARMED;
      S_ARMED:   if (start_cap) state_nxt = S_CAPTURE;
      S_CAPTURE: if (sample_en && (wr_ptr == ADDR_W'(DEPTH - 1))) state_nxt = S_DONE;
      S_DONE:    if (arm) state_nxt = S_ARMED;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // ---- FSM: output decode, registered so status aligns with the state ----
  always_comb begin
    busy_nxt = (state_nxt == S_ARMED) || (state_nxt == S_CAPTURE);
    done_nxt = (state_nxt == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // ---- Trigger history and write pointer ----
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_vld <= 1'b0;
      wr_ptr   <= '0;
    end else if (arm_acc) begin
      // The sample arriving alongside arm is deliberately not used.
      prev_vld <= 1'b0;
      wr_ptr   <= '0;
    end else if (start_cap) begin
      wr_ptr   <= ADDR_W'(1);
    end else if (armed_strobe) begin
      prev_vld <= 1'b1;
    end else if ((state == S_CAPTURE) && sample_en) begin
      // Natural wrap returns the pointer to 0 after the last address.
      wr_ptr   <= wr_ptr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (armed_strobe && !start_cap) begin
      prev_sample <= signal_in;
    end
  end

  // ---- Frame buffer: one write port, one registered read port ----
  // Reset gates the write so an abort mid-capture stops on the reset cycle.
  assign we    = !reset && (start_cap || ((state == S_CAPTURE) && sample_en));
  assign waddr = (state == S_ARMED) ? '0 : wr_ptr;
  assign wdata = {signal_in, mod_in};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read-before-write on address collision falls out of the NBA ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_waveform_capture_buffer.sv
module tb_waveform_capture_buffer;

  localparam int W     = 12;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
`ifdef CAPTURE_TIMEOUT_EN
  localparam int TO    = 16;
`else
  localparam int TO    = 4096;
`endif

  logic          clk;
  logic          reset;
  logic          sample_en;
  logic [W-1:0]  signal_in;
  logic [W-1:0]  mod_in;
  logic          arm;
  logic [W-1:0]  trig_level;
  logic [AW-1:0] rd_addr;
  logic [2*W-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          timed_out;

  waveform_capture_buffer #(
    .W(W), .DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .signal_in(signal_in),
    .mod_in(mod_in), .arm(arm), .trig_level(trig_level), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .timed_out(timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t rdq[$];
  exp_t stq[$];

  int   checks = 0;
  int   passed = 0;
  logic rd_req = 1'b0;
  logic end_req = 1'b0;
  int   end_chk = 0;

  function automatic logic [W-1:0] mf(input logic [W-1:0] v);
    return v ^ 12'h5A5;
  endfunction

  // Scoreboard monitor: reads are due one cycle after the request, status
  // expectations are due in the cycle they were queued.
  initial begin : monitor
    logic rd_pend;
    exp_t e;
    rd_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        checks++;
        if (rdq.size() == 0) begin
          $display("FAIL rd_unexpected: got %h required no pending read", rd_data);
        end else begin
          e = rdq.pop_front();
          if ({8'h00, rd_data} === e.exp) passed++;
          else $display("FAIL %s: rd_data got %h required %h", e.name, rd_data, e.exp[23:0]);
        end
      end
      rd_pend = rd_req;
      while (stq.size() > 0) begin
        e = stq.pop_front();
        checks++;
        if ({29'd0, busy, done, timed_out} === e.exp) passed++;
        else $display("FAIL %s: {busy,done,timed_out} got %b%b%b required %b",
                      e.name, busy, done, timed_out, e.exp[2:0]);
      end
      if (end_req && end_chk == 0) begin
        checks++;
        if (rdq.size() == 0 && !rd_pend) passed++;
        else $display("FAIL queue_drain: %0d reads outstanding required 0", rdq.size());
        end_chk = 1;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    arm       = 1'b0;
    rd_req    = 1'b0;
  endtask

  task automatic strobe(input logic [W-1:0] s, input logic [W-1:0] m);
    sample_en = 1'b1;
    signal_in = s;
    mod_in    = m;
    tick();
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [2*W-1:0] e, input string n);
    exp_t x;
    x.name = n;
    x.exp  = {8'h00, e};
    rd_addr = a;
    rd_req  = 1'b1;
    rdq.push_back(x);
  endtask

  task automatic st(input logic b, input logic d, input logic t, input string n);
    exp_t x;
    x.name = n;
    x.exp  = {29'd0, b, d, t};
    stq.push_back(x);
  endtask

  initial begin : stimulus
    reset = 1'b1; sample_en = 1'b0; signal_in = '0; mod_in = '0;
    arm = 1'b0; trig_level = '0; rd_addr = '0;
    tick();
    tick();
    rd(8'd0, 24'h000000, "reset_rd_data");
    tick();
    st(1'b0, 1'b0, 1'b0, "reset_status");
    reset = 1'b0;
    tick();

    // Ramp through the threshold: trigger on the sample equal to 100.
    trig_level = 12'd100;
    arm = 1'b1;
    tick();
    st(1'b1, 1'b0, 1'b0, "t1_armed");
    for (int v = 90; v <= 355; v++) begin
      strobe(W'(v), mf(W'(v)));
      if (v == 354) st(1'b1, 1'b0, 1'b0, "t1_before_last");
    end
    st(1'b0, 1'b1, 1'b0, "t1_done");
    for (int v = 356; v <= 400; v++) strobe(W'(v), mf(W'(v)));
    st(1'b0, 1'b1, 1'b0, "t1_done_hold");
    rd(8'd0,   {12'd100, mf(12'd100)}, "t1_addr0");
    tick();
    rd(8'd255, {12'd355, mf(12'd355)}, "t1_addr255");
    tick();
    rd(8'd128, {12'd228, mf(12'd228)}, "t1_addr128");
    tick();

    // Arm with a coincident sample (discarded), then 200, 50, 150.
    arm = 1'b1; sample_en = 1'b1; signal_in = 12'd50; mod_in = 12'd0;
    tick();
    st(1'b1, 1'b0, 1'b0, "t2_arm_from_done");
    strobe(12'd200, mf(12'd200));
    strobe(12'd50,  mf(12'd50));
    strobe(12'd150, mf(12'd150));
    st(1'b1, 1'b0, 1'b0, "t2_capturing");
    for (int i = 1; i <= 255; i++) begin
      if (i == 40) arm = 1'b1;
      if (i == 5) rd(8'd0, {12'd150, mf(12'd150)}, "t2_addr0");
      strobe(W'(1000 + i), mf(W'(1000 + i)));
    end
    st(1'b0, 1'b1, 1'b0, "t3_done_despite_arm");
    rd(8'd40,  {12'd1040, mf(12'd1040)}, "t3_addr40");
    tick();
    rd(8'd255, {12'd1255, mf(12'd1255)}, "t3_addr255");
    tick();
    rd(8'd1,   {12'd1001, mf(12'd1001)}, "t3_addr1");
    tick();
    arm = 1'b1;
    tick();
    st(1'b1, 1'b0, 1'b0, "t3_rearm");

    // Reset mid-capture at pointer 100.
    strobe(12'd0,   mf(12'd0));
    strobe(12'd120, mf(12'd120));
    for (int i = 1; i <= 99; i++) strobe(W'(2000 + i), mf(W'(2000 + i)));
    st(1'b1, 1'b0, 1'b0, "t4_busy_before_reset");
    reset = 1'b1; sample_en = 1'b1; signal_in = 12'd3333; mod_in = 12'd0;
    tick();
    st(1'b0, 1'b0, 1'b0, "t4_reset_status");
    reset = 1'b0;
    tick();
    rd(8'd50,  {12'd2050, mf(12'd2050)}, "t4_addr50");
    tick();
    rd(8'd100, {12'd1100, mf(12'd1100)}, "t4_addr100_unwritten");
    tick();
    rd(8'd0,   {12'd120, mf(12'd120)}, "t4_addr0");
    tick();

    // Read-before-write collision at address 10.
    arm = 1'b1;
    tick();
    strobe(12'd0,   mf(12'd0));
    strobe(12'd100, mf(12'd100));
    for (int i = 1; i <= 9; i++) strobe(W'(3000 + i), mf(W'(3000 + i)));
    rd(8'd10, {12'd2010, mf(12'd2010)}, "t5_rbw_old");
    strobe(12'hABC, 12'h123);
    rd(8'd10, 24'hABC123, "t5_rbw_new");
    tick();

`ifdef CAPTURE_TIMEOUT_EN
    // Constant zero never crosses; the 17th strobe is force-triggered.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    arm = 1'b1;
    tick();
    for (int i = 1; i <= 16; i++) strobe(12'd0, W'(i));
    st(1'b1, 1'b0, 1'b0, "to_after16");
    strobe(12'd0, 12'h777);
    st(1'b1, 1'b0, 1'b1, "to_fired");
    for (int i = 1; i <= 255; i++) strobe(12'd5, W'(i));
    st(1'b0, 1'b1, 1'b1, "to_done");
    rd(8'd0, 24'h000777, "to_addr0");
    tick();
    rd(8'd1, 24'h005001, "to_addr1");
    tick();
    arm = 1'b1;
    tick();
    st(1'b1, 1'b0, 1'b0, "to_cleared_by_arm");
`endif

    tick();
    end_req = 1'b1;
    tick();
    tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
